// File: rtl/wb_loader_if.sv
// Bundles the byte stream and the Wishbone write/read channel used by wb_loader.
// master = loader side, slave = stream source plus Wishbone target side.
interface wb_loader_if;
  logic [7:0]  s_dat_i;
  logic        s_vld_i;
  logic        s_rdy_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_be_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    input  s_dat_i, s_vld_i, wb_dat_i, wb_ack_i,
    output s_rdy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_be_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output s_dat_i, s_vld_i, wb_dat_i, wb_ack_i,
    input  s_rdy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_be_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/wb_loader.sv
// Streams a length-prefixed little-endian image into RAM over Wishbone, holding the core in reset until done.
// Optional readback check of every written word: define WB_LOADER_VERIFY_EN.
module wb_loader #(
  parameter logic [31:0] BASEADR = 32'h0,
  parameter int unsigned ACKTMO  = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_loader_if.master  bus,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic         cpu_rst_no
);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_WR,
    ST_RD,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam bit          TMO_EN   = (ACKTMO != 0);
  localparam logic [31:0] TMO_LAST = 32'(ACKTMO - 1);

  state_t      state_reg, state_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] word_reg, word_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic [31:0] idx_reg, idx_next;
  logic [31:0] tmo_reg, tmo_next;
  logic        got_byte_reg, got_byte_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [31:0] adr_reg, adr_next;
  logic [31:0] dat_reg, dat_next;
  logic        err_reg, err_next;

  logic        s_rdy;
  logic        byte_fire;
  logic        ack_hit;
  logic        tmo_hit;
  logic [31:0] asm_word;
  logic [31:0] idx_inc;

  // Incoming byte lands in the lane selected by the byte counter (little-endian).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign asm_word[gi*8 +: 8] = (byte_cnt_reg == 2'(gi)) ? bus.s_dat_i
                                                            : word_reg[gi*8 +: 8];
    end
  endgenerate

  assign s_rdy     = !rst_i && ((state_reg == ST_HDR) || (state_reg == ST_DATA));
  assign byte_fire = bus.s_vld_i && s_rdy;
  assign ack_hit   = req_reg && bus.wb_ack_i;
  assign tmo_hit   = TMO_EN && req_reg && !bus.wb_ack_i && (tmo_reg == TMO_LAST);
  assign idx_inc   = idx_reg + 32'd1;

`ifndef WB_LOADER_VERIFY_EN
  logic unused_rd_dat;
  assign unused_rd_dat = ^bus.wb_dat_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_HDR;
      count_reg    <= '0;
      word_reg     <= '0;
      byte_cnt_reg <= '0;
      idx_reg      <= '0;
      tmo_reg      <= '0;
      got_byte_reg <= 1'b0;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      word_reg     <= word_next;
      byte_cnt_reg <= byte_cnt_next;
      idx_reg      <= idx_next;
      tmo_reg      <= tmo_next;
      got_byte_reg <= got_byte_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      adr_reg      <= adr_next;
      dat_reg      <= dat_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    word_next     = word_reg;
    byte_cnt_next = byte_cnt_reg;
    idx_next      = idx_reg;
    tmo_next      = tmo_reg;
    got_byte_next = got_byte_reg;
    req_next      = req_reg;
    we_next       = we_reg;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    err_next      = err_reg;

    if (req_reg && !bus.wb_ack_i) begin
      tmo_next = tmo_reg + 32'd1;
    end

    unique case (state_reg)
      ST_HDR: begin
        if (byte_fire) begin
          got_byte_next = 1'b1;
          word_next     = asm_word;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            count_next = asm_word;
            state_next = (asm_word == 32'd0) ? ST_DONE : ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (byte_fire) begin
          word_next     = asm_word;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            // Request is registered here so it is stable from its first cycle.
            state_next = ST_WR;
            req_next   = 1'b1;
            we_next    = 1'b1;
            adr_next   = BASEADR + {idx_reg[29:0], 2'b00};
            dat_next   = asm_word;
            tmo_next   = '0;
          end
        end
      end

      ST_WR: begin
        if (tmo_hit) begin
          req_next   = 1'b0;
          we_next    = 1'b0;
          err_next   = 1'b1;
          state_next = ST_ERR;
        end else if (ack_hit) begin
          req_next = 1'b0;
          we_next  = 1'b0;
          idx_next = idx_inc;
`ifdef WB_LOADER_VERIFY_EN
          state_next = ST_RD;
`else
          state_next = (idx_inc < count_reg) ? ST_DATA : ST_DONE;
`endif
        end
      end

`ifdef WB_LOADER_VERIFY_EN
      ST_RD: begin
        // First RD cycle is the idle gap; the read request goes out on the next edge.
        if (!req_reg) begin
          req_next = 1'b1;
          we_next  = 1'b0;
          tmo_next = '0;
        end else if (tmo_hit) begin
          req_next   = 1'b0;
          err_next   = 1'b1;
          state_next = ST_ERR;
        end else if (ack_hit) begin
          req_next = 1'b0;
          if (bus.wb_dat_i != dat_reg) begin
            err_next   = 1'b1;
            state_next = ST_ERR;
          end else begin
            state_next = (idx_reg < count_reg) ? ST_DATA : ST_DONE;
          end
        end
      end
`endif

      ST_DONE: begin
        state_next = ST_DONE;
      end

      default: begin
        state_next = ST_ERR;
        req_next   = 1'b0;
        we_next    = 1'b0;
      end
    endcase
  end

  assign bus.s_rdy_o   = s_rdy;
  assign bus.wb_cyc_o  = req_reg;
  assign bus.wb_stb_o  = req_reg;
  assign bus.wb_we_o   = we_reg;
  assign bus.wb_be_o   = req_reg ? 4'hF : 4'h0;
  assign bus.wb_adr_o  = adr_reg;
  assign bus.wb_dat_o  = dat_reg;

  assign busy_o     = ((state_reg == ST_HDR) && got_byte_reg) || (state_reg == ST_DATA) ||
                      (state_reg == ST_WR) || (state_reg == ST_RD);
  assign done_o     = (state_reg == ST_DONE);
  assign cpu_rst_no = (state_reg == ST_DONE);
  assign err_o      = err_reg;

endmodule

// File: tb/tb_wb_loader.sv
// Self-checking bench for wb_loader: scoreboarded Wishbone writes plus reset, timeout and verify scenarios.
module tb_wb_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_loader_if bus();
  logic busy, done, err, cpu_rst_n;

  wb_loader #(.BASEADR(32'h0), .ACKTMO(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .cpu_rst_no (cpu_rst_n)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  be;
    int          cycles;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  int          resp_delay = 1;
  bit          resp_en    = 1'b1;
  logic [31:0] rd_data    = 32'h0;
  bit          toggle_vld = 1'b0;
  int          stb_cnt    = 0;
  int          n_reads    = 0;
  int          stable_errs = 0;
  int          rdy_errs   = 0;
  int          cyc_cycles = 0;
  logic [31:0] cap_adr, cap_dat;

  // Wishbone target: acks resp_delay cycles after stb rises, records each write.
  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wb_cyc_o) cyc_cycles++;
      if (bus.wb_ack_i) begin
        bus.wb_ack_i = 1'b0;
        stb_cnt = 0;
      end else if (bus.wb_stb_o) begin
        if (stb_cnt == 0) begin
          cap_adr = bus.wb_adr_o;
          cap_dat = bus.wb_dat_o;
        end else if (bus.wb_adr_o !== cap_adr || bus.wb_dat_o !== cap_dat) begin
          stable_errs++;
        end
        if (bus.s_rdy_o) rdy_errs++;
        if (resp_en && stb_cnt == resp_delay) begin
          bus.wb_ack_i = 1'b1;
          if (bus.wb_we_o) begin
            wr_t o;
            o.adr = bus.wb_adr_o;
            o.dat = bus.wb_dat_o;
            o.be = bus.wb_be_o;
            o.cycles = stb_cnt + 1;
            obs_q.push_back(o);
          end else begin
            n_reads++;
            bus.wb_dat_i = rd_data;
          end
        end
        stb_cnt++;
      end else begin
        stb_cnt = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int w;
    if (toggle_vld) begin
      bus.s_vld_i = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.s_dat_i = b;
    bus.s_vld_i = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.s_rdy_o && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!bus.s_rdy_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_byte: byte %02h never accepted, s_rdy_o=%b required 1", b, bus.s_rdy_o);
    end
    @(posedge clk);
    #1;
    bus.s_vld_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic push_exp(input logic [31:0] adr, input logic [31:0] dat);
    wr_t e;
    e.adr = adr;
    e.dat = dat;
    e.be = 4'hF;
    e.cycles = 0;
    exp_q.push_back(e);
  endtask

  task automatic wait_end(input string name);
    int w;
    w = 0;
    while (!done && !err && w < 500) begin
      w++;
      @(posedge clk);
      #1;
    end
    if (!done && !err) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_end: neither done_o nor err_o within 500 cycles", name);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    n_reads = 0;
    stable_errs = 0;
    rdy_errs = 0;
    cyc_cycles = 0;
    toggle_vld = 1'b0;
    resp_en = 1'b1;
    resp_delay = 1;
  endtask

  task automatic test_reset();
    bus.s_vld_i = 1'b1;
    bus.s_dat_i = 8'hA5;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.s_rdy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rdy: s_rdy_o=%b required 0", bus.s_rdy_o);
    end
    n_cmp++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_be_o, done, err, cpu_rst_n, busy} !== 11'h0) begin
      n_bad++;
      $display("FAIL reset_outs: cyc/stb/we/be/done/err/cpu_rst_n/busy=%b required 0",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_be_o, done, err, cpu_rst_n, busy});
    end
    @(posedge clk);
    #1;
    bus.s_vld_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.s_rdy_o, busy, done} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_release: rdy/busy/done=%b required 100", {bus.s_rdy_o, busy, done});
    end
  endtask

  task automatic test_load();
    do_reset();
    push_exp(32'h0, 32'h11223344);
    push_exp(32'h4, 32'hDEADBEEF);
    send_byte(8'h02);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL load_busy: busy_o=%b after first byte, required 1", busy);
    end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_word(32'h11223344);
    send_word(32'hDEADBEEF);
    wait_end("load");
    while (exp_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL load_wr: no write seen, required adr %h dat %h", e.adr, e.dat);
      end else begin
        o = obs_q.pop_front();
        if ({o.adr, o.dat, o.be} !== {e.adr, e.dat, e.be}) begin
          n_bad++;
          $display("FAIL load_wr: adr %h dat %h be %h, required adr %h dat %h be %h",
                   o.adr, o.dat, o.be, e.adr, e.dat, e.be);
        end
      end
    end
    n_cmp++;
    if ({done, cpu_rst_n, bus.s_rdy_o, err, busy, obs_q.size() == 0} !== 6'b110001) begin
      n_bad++;
      $display("FAIL load_final: done/cpu_rst_n/rdy/err/busy/noextra=%b required 110001",
               {done, cpu_rst_n, bus.s_rdy_o, err, busy, obs_q.size() == 0});
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_word(32'h0);
    n_cmp++;
    if ({done, cpu_rst_n, bus.s_rdy_o, busy} !== 4'b1100) begin
      n_bad++;
      $display("FAIL zero_done: done/cpu_rst_n/rdy/busy=%b required 1100", {done, cpu_rst_n, bus.s_rdy_o, busy});
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (cyc_cycles !== 0) begin
      n_bad++;
      $display("FAIL zero_cyc: wb_cyc_o high for %0d cycles, required 0", cyc_cycles);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    toggle_vld = 1'b1;
    resp_delay = 5;
    push_exp(32'h0, 32'hA5A55A5A);
    push_exp(32'h4, 32'h01020304);
    send_word(32'h2);
    send_word(32'hA5A55A5A);
    send_word(32'h01020304);
    wait_end("bp");
    while (exp_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL bp_wr: no write seen, required adr %h dat %h", e.adr, e.dat);
      end else begin
        o = obs_q.pop_front();
        if ({o.adr, o.dat, o.be} !== {e.adr, e.dat, e.be} || o.cycles != 6) begin
          n_bad++;
          $display("FAIL bp_wr: adr %h dat %h be %h stb %0d cyc, required adr %h dat %h be F stb 6 cyc",
                   o.adr, o.dat, o.be, o.cycles, e.adr, e.dat);
        end
      end
    end
    n_cmp++;
    if (stable_errs !== 0 || rdy_errs !== 0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_stable: unstable %0d rdy_during_wr %0d done %b, required 0 0 1",
               stable_errs, rdy_errs, done);
    end
  endtask

  task automatic test_timeout();
    int n, w, acc;
    do_reset();
    resp_en = 1'b0;
    send_word(32'h1);
    send_word(32'h55AA55AA);
    w = 0;
    while (!bus.wb_stb_o && w < 20) begin
      w++;
      @(posedge clk);
      #1;
    end
    n = 0;
    while (bus.wb_stb_o && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (n != 16) begin
      n_bad++;
      $display("FAIL tmo_len: stb high %0d cycles, required 16", n);
    end
    n_cmp++;
    if ({err, cpu_rst_n, done, busy, bus.wb_cyc_o} !== 5'b10000) begin
      n_bad++;
      $display("FAIL tmo_state: err/cpu_rst_n/done/busy/cyc=%b required 10000",
               {err, cpu_rst_n, done, busy, bus.wb_cyc_o});
    end
    bus.s_dat_i = 8'h77;
    bus.s_vld_i = 1'b1;
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.s_rdy_o) acc++;
    end
    bus.s_vld_i = 1'b0;
    n_cmp++;
    if (acc != 0 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_sticky: s_rdy_o high %0d cycles err %b, required 0 cycles err 1", acc, err);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int w;
    do_reset();
    resp_en = 1'b0;
    send_word(32'h1);
    send_word(32'h99887766);
    w = 0;
    while (!bus.wb_stb_o && w < 20) begin
      w++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, err} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid_drop: cyc/stb/err=%b required 000", {bus.wb_cyc_o, bus.wb_stb_o, err});
    end
    rst = 1'b0;
    resp_en = 1'b1;
    obs_q.delete();
    push_exp(32'h0, 32'hCAFEF00D);
    send_word(32'h1);
    send_word(32'hCAFEF00D);
    wait_end("rstmid");
    while (exp_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL rstmid_wr: no write seen, required adr %h dat %h", e.adr, e.dat);
      end else begin
        o = obs_q.pop_front();
        if ({o.adr, o.dat} !== {e.adr, e.dat}) begin
          n_bad++;
          $display("FAIL rstmid_wr: adr %h dat %h, required adr %h dat %h", o.adr, o.dat, e.adr, e.dat);
        end
      end
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_done: done_o=%b required 1", done);
    end
  endtask

  task automatic test_verify();
    do_reset();
    rd_data = 32'h0;
    push_exp(32'h0, 32'h11223344);
    send_word(32'h1);
    send_word(32'h11223344);
    wait_end("verify");
    repeat (2) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL verify_wr: no write seen, required adr %h dat %h", e.adr, e.dat);
      end else begin
        o = obs_q.pop_front();
        if ({o.adr, o.dat} !== {e.adr, e.dat}) begin
          n_bad++;
          $display("FAIL verify_wr: adr %h dat %h, required adr %h dat %h", o.adr, o.dat, e.adr, e.dat);
        end
      end
    end
`ifdef WB_LOADER_VERIFY_EN
    n_cmp++;
    if ({err, done, cpu_rst_n} !== 3'b100 || n_reads != 1) begin
      n_bad++;
      $display("FAIL verify_result: err/done/cpu_rst_n=%b reads %0d, required 100 reads 1",
               {err, done, cpu_rst_n}, n_reads);
    end
`else
    n_cmp++;
    if ({err, done, cpu_rst_n} !== 3'b011 || n_reads != 0) begin
      n_bad++;
      $display("FAIL verify_result: err/done/cpu_rst_n=%b reads %0d, required 011 reads 0",
               {err, done, cpu_rst_n}, n_reads);
    end
`endif
  endtask

  initial begin
    bus.s_vld_i = 1'b0;
    bus.s_dat_i = 8'h0;
    test_reset();
    $display("test_reset done: %0d compared", n_cmp);
    test_load();
    $display("test_load done: %0d compared", n_cmp);
    test_zero_len();
    $display("test_zero_len done: %0d compared", n_cmp);
    test_back_to_back();
    $display("test_back_to_back done: %0d compared", n_cmp);
    test_timeout();
    $display("test_timeout done: %0d compared", n_cmp);
    test_reset_mid_write();
    $display("test_reset_mid_write done: %0d compared", n_cmp);
    test_verify();
    $display("test_verify done: %0d compared", n_cmp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_loader.md
Name: wb_loader

Overview:
- Wishbone initiator that loads firmware into SoC RAM from a byte stream, such as a UART receiver or a test harness.
- Holds the FazyRV core in reset while loading; releases it once the image is written.
- Sits on the memory bus next to the core's initiator ports, so the SoC RAM and GPIO now have a second initiator besides the CPU.
- Turns a serial byte source into 32-bit Wishbone write cycles.

Parameters:
- BASEADR, 'h0: byte address of the first word written. Must be word-aligned.
- ACKTMO, 256: maximum cycles a request may wait for an ack. 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- s_dat_i  in  8  stream byte.
- s_vld_i  in  1  stream byte valid.
- s_rdy_o  out  1  loader accepts a byte.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  write enable.
- wb_be_o  out  4  byte enables.
- wb_adr_o  out  32  byte address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data (used only with verify).
- wb_ack_i  in  1  acknowledge.
- busy_o  out  1  load in progress.
- done_o  out  1  image fully written.
- err_o  out  1  timeout or verify mismatch, sticky.
- cpu_rst_no  out  1  active-low reset to the core; 1 only in DONE.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- While rst_i is high, and at the first edge after it falls:
  - state HDR; all wb_* outputs 0; done_o=0, err_o=0, cpu_rst_no=0.
  - s_rdy_o=0 while rst_i is high.
  - byte, word and address counters cleared.
- A byte transfers on a rising edge with s_vld_i & s_rdy_o.
- s_rdy_o=1 only in HDR and DATA. busy_o=1 in HDR after the first accepted byte, and in DATA, WR, RD.
- HDR:
  - Collects 4 bytes little-endian into a 32-bit word count N.
  - On the 4th byte: N==0 goes to DONE, otherwise DATA.
- DATA:
  - Collects 4 bytes little-endian: the first byte is [7:0].
  - On the 4th byte goes to WR. The request appears the next cycle.
- WR:
  - Drives wb_cyc_o=wb_stb_o=wb_we_o=1, wb_be_o=4'hF.
  - wb_adr_o = BASEADR + 4*idx, 32-bit wrap-around.
  - wb_dat_o = assembled word.
  - All of these are registered and held stable until wb_ack_i is sampled high.
  - On the ack edge, cyc/stb/we drop and idx increments.
  - Next state: DATA if idx < N, else DONE.
  - Back-to-back requests have at least one idle cycle between them.
- wb_ack_i outside an active request is ignored. wb_dat_i is ignored unless verify is enabled.
- Timeout (ACKTMO≠0):
  - A counter clears when a request starts and increments each cycle stb=1 & ack=0.
  - When it reaches ACKTMO, cyc/stb drop on that edge, err_o=1, state goes to ERR.
- ERR: sticky. s_rdy_o=0, busy_o=0, cpu_rst_no=0. Left only by rst_i.
- DONE: done_o=1, cpu_rst_no=1, s_rdy_o=0, busy_o=0. Held until rst_i.
- rst_i during an active request:
  - cyc/stb drop at that edge.
  - The partial word and the count are discarded.
  - A new load starts from HDR.
- Stream bytes presented while s_rdy_o=0 are not consumed. The source must hold them.

Optional Feature:
- Macro: WB_LOADER_VERIFY_EN.
- With the macro defined:
  - After each write ack, the next cycle enters RD.
  - RD drives cyc=stb=1, we=0, be=4'hF, same address.
  - On ack, wb_dat_i is compared with the written word. Match continues as after WR; mismatch sets err_o=1 and goes to ERR.
  - The timeout applies to RD as well.
- Without the macro: no read cycles are issued, and wb_dat_i is unused.

Test Plan:
- Load, BASEADR=0:
  - Stream 02 00 00 00, 44 33 22 11, EF BE AD DE; responder acks 1 cycle after stb.
  - Expect writes adr 0x0 dat 0x11223344, then adr 0x4 dat 0xDEADBEEF, be=F.
  - Then done_o=1, cpu_rst_no=1, s_rdy_o=0.
- Zero length: stream 00 00 00 00 → DONE on the edge after the 4th byte; wb_cyc_o never asserted.
- Backpressure and wait states:
  - s_vld_i toggles every cycle; responder acks 5 cycles after stb.
  - Expect stb, adr and dat stable for all 6 cycles, s_rdy_o=0 during WR, written data unchanged.
- Timeout:
  - ACKTMO=16, responder never acks.
  - Expect stb to drop after 16 cycles, err_o=1, cpu_rst_no=0, and further bytes not accepted.
- Reset mid-write:
  - Assert rst_i for one cycle while stb=1 → cyc/stb=0 next cycle.
  - A fresh 1-word image then writes to BASEADR correctly.
- Verify, macro defined:
  - Readback returns 0x00000000 for written 0x11223344 → err_o=1, done_o=0.
  - Same stimulus without the macro → done_o=1, no read cycles.
